skew_feed_ctrl: RTL and testbench

- Sequencer that feeds a stream of `size`-lane vectors into the systolic datapath with per-lane diagonal skew: lane i is delayed i cycles more than lane 0.
- Runs one programmed-length burst per `start` and accepts beats over a valid/ready handshake.
- Drains the skew pipeline after the last beat, then pulses `done`.
- Sits between the operand source (buffer or DMA) and the array edge; it replaces hand-instantiated per-lane delay chains.

---
 rtl/skew_feed_ctrl.sv | 128 ++++++++++++
 tb/tb_skew_feed_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: burst sequencer feeding a systolic array edge.
// Lane i of each accepted beat is delayed i extra cycles (diagonal skew).
module skew_feed_ctrl #(
  parameter int data_size = 16,
  parameter int size      = 4,
  parameter int len_w     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [len_w-1:0]          len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [data_size*size-1:0] bus_in,
  output logic [data_size*size-1:0] bus_out,
  output logic [size-1:0]           lane_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int dw = $clog2(size + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [len_w-1:0] len_q;
  logic [len_w-1:0] beat_cnt;
  logic [dw-1:0]    drain_cnt;
  logic             stream;
  logic             accept;
  logic             last_beat;
  logic             launch;

  assign stream    = (state == STREAM);
  assign in_ready  = stream;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign accept    = in_valid & stream;
  assign last_beat = accept && ((beat_cnt + len_w'(1)) == len_q);
  assign launch    = (state == IDLE) && start && (len != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = (len != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (last_beat) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == dw'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (launch) begin
        len_q    <= len;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + len_w'(1);
      end
      if (last_beat) begin
        drain_cnt <= dw'(size);
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt - dw'(1);
      end
    end
  end

  // Bubbles enter as zero data so invalid lanes read zero at the output.
  for (genvar i = 0; i < size; i++) begin : g_lane
    logic [data_size-1:0] pipe [i+1];
    logic [i:0]           vld;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) begin
          pipe[k] <= '0;
        end
        vld <= '0;
      end else begin
        pipe[0] <= accept ? bus_in[data_size*i +: data_size] : '0;
        vld[0]  <= accept;
        for (int k = 1; k <= i; k++) begin
          pipe[k] <= pipe[k-1];
          vld[k]  <= vld[k-1];
        end
      end
    end

    assign bus_out[data_size*i +: data_size] = pipe[i];
    assign lane_valid[i]                     = vld[i];
  end

endmodule

// File: tb/tb_skew_feed_ctrl.sv
// tb_skew_feed_ctrl: directed bench for skew_feed_ctrl.
// Covers size=4 bursts, bubbles, zero length, reset and a size=1 copy.
module tb_skew_feed_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] bus_in;
  logic [63:0] bus_out;
  logic [3:0]  lane_valid;
  logic        busy;
  logic        done;

  logic        start1;
  logic [15:0] len1;
  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] bus_in1;
  logic [15:0] bus_out1;
  logic [0:0]  lane_valid1;
  logic        busy1;
  logic        done1;

  int checks;
  int errors;

  skew_feed_ctrl #(.data_size(16), .size(4), .len_w(16)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .bus_in(bus_in),
    .bus_out(bus_out), .lane_valid(lane_valid), .busy(busy), .done(done)
  );

  skew_feed_ctrl #(.data_size(16), .size(1), .len_w(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .len(len1),
    .in_valid(in_valid1), .in_ready(in_ready1), .bus_in(bus_in1),
    .bus_out(bus_out1), .lane_valid(lane_valid1), .busy(busy1),
    .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, busy, done, lane_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=%b",
               {in_ready, busy, done, lane_valid}, 7'b0);
    end
    checks++;
    if (bus_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus got=%h exp=0", bus_out);
    end
    checks++;
    if ({in_ready1, busy1, done1, lane_valid1, bus_out1} !== 20'h0) begin
      errors++;
      $display("FAIL reset_size1 got=%h exp=0",
               {in_ready1, busy1, done1, lane_valid1, bus_out1});
    end
  endtask

  task automatic test_basic();
    logic [63:0] beats [3];
    logic [2:0]  ectl;
    logic [3:0]  elv;
    logic [63:0] ebus;
    int          k;
    beats[0] = 64'h0001_0002_0003_0004;
    beats[1] = 64'h0011_0012_0013_0014;
    beats[2] = 64'h0021_0022_0023_0024;
    for (int c = 0; c <= 9; c++) begin
      start    = (c == 0);
      len      = 16'd3;
      in_valid = 1'b1;
      bus_in   = (c >= 1 && c <= 3) ? beats[c-1] : 64'hdead_beef_cafe_f00d;
      ectl = {(c >= 1 && c <= 3), (c >= 1 && c <= 8), (c == 8)};
      elv  = '0;
      ebus = '0;
      for (int i = 0; i < 4; i++) begin
        k = c - 2 - i;
        if (k >= 0 && k <= 2) begin
          elv[i]          = 1'b1;
          ebus[16*i +: 16] = beats[k][16*i +: 16];
        end
      end
      checks++;
      if ({in_ready, busy, done} !== ectl) begin
        errors++;
        $display("FAIL basic_ctl c=%0d got=%b exp=%b", c,
                 {in_ready, busy, done}, ectl);
      end
      checks++;
      if (lane_valid !== elv || bus_out !== ebus) begin
        errors++;
        $display("FAIL basic_data c=%0d got=%b/%h exp=%b/%h", c,
                 lane_valid, bus_out, elv, ebus);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_bubbles();
    for (int c = 0; c <= 9; c++) begin
      start    = (c == 0);
      len      = 16'd2;
      in_valid = (c == 1) || (c == 3);
      unique case (c)
        1:       bus_in = 64'h0101_0202_0303_0404;
        3:       bus_in = 64'h0505_0606_0707_0808;
        default: bus_in = 64'hffff_ffff_ffff_ffff;
      endcase
      if (c == 2 || c == 3 || c == 4) begin
        checks++;
        if (lane_valid[0] !== (c != 3)) begin
          errors++;
          $display("FAIL bubble_lv0 c=%0d got=%b exp=%b", c,
                   lane_valid[0], (c != 3));
        end
      end
      if (c == 3) begin
        checks++;
        if (bus_out[15:0] !== 16'h0000) begin
          errors++;
          $display("FAIL bubble_lane0 got=%h exp=0000", bus_out[15:0]);
        end
      end
      if (c == 6) begin
        checks++;
        if (lane_valid[3] !== 1'b0 || bus_out[63:48] !== 16'h0000) begin
          errors++;
          $display("FAIL bubble_lane3 got=%b/%h exp=0/0000",
                   lane_valid[3], bus_out[63:48]);
        end
      end
      if (c == 7) begin
        checks++;
        if (bus_out[63:48] !== 16'h0505) begin
          errors++;
          $display("FAIL bubble_b1_lane3 got=%h exp=0505", bus_out[63:48]);
        end
      end
      checks++;
      if (done !== (c == 8)) begin
        errors++;
        $display("FAIL bubble_done c=%0d got=%b exp=%b", c, done, (c == 8));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_zero_len();
    in_valid = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      start = (c == 0);
      len   = 16'd0;
      checks++;
      if ({in_ready, busy, done} !== {1'b0, (c == 1), (c == 1)}) begin
        errors++;
        $display("FAIL zero_len c=%0d got=%b exp=%b", c,
                 {in_ready, busy, done}, {1'b0, (c == 1), (c == 1)});
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_start_busy();
    int ndone;
    ndone = 0;
    for (int c = 0; c <= 10; c++) begin
      start    = (c == 0) || (c == 2) || (c == 7);
      len      = (c == 0) ? 16'd2 : 16'd5;
      in_valid = 1'b1;
      bus_in   = 64'h1000_2000_3000_4000 + 64'(c);
      if (done) ndone++;
      checks++;
      if ({in_ready, busy, done} !==
          {(c == 1 || c == 2), (c >= 1 && c <= 7), (c == 7)}) begin
        errors++;
        $display("FAIL start_busy c=%0d got=%b exp=%b", c,
                 {in_ready, busy, done},
                 {(c == 1 || c == 2), (c >= 1 && c <= 7), (c == 7)});
      end
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL start_busy_ndone got=%0d exp=1", ndone);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 10; c++) begin
      start    = (c == 0) || (c == 4);
      len      = 16'd1;
      in_valid = (c == 1) || (c == 5);
      bus_in   = (c == 5) ? 64'h00aa_00bb_00cc_00dd : 64'h0777_0666_0555_0444;
      reset    = (c == 3);
      if (c == 4) begin
        checks++;
        if ({lane_valid, busy, done} !== 6'b0 || bus_out !== 64'h0) begin
          errors++;
          $display("FAIL reset_mid got=%b/%h exp=0/0",
                   {lane_valid, busy, done}, bus_out);
        end
      end
      if (c == 9) begin
        checks++;
        if (lane_valid !== 4'b1000 || bus_out !== 64'h00aa_0000_0000_0000) begin
          errors++;
          $display("FAIL reset_mid_lane3 got=%b/%h exp=1000/00aa000000000000",
                   lane_valid, bus_out);
        end
      end
      if (c >= 4) begin
        checks++;
        if (done !== (c == 10)) begin
          errors++;
          $display("FAIL reset_mid_done c=%0d got=%b exp=%b", c, done,
                   (c == 10));
        end
      end
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_size1();
    logic [15:0] ebus;
    for (int c = 0; c <= 5; c++) begin
      start1    = (c == 0);
      len1      = 16'd2;
      in_valid1 = 1'b1;
      unique case (c)
        1:       bus_in1 = 16'h1234;
        2:       bus_in1 = 16'h5678;
        default: bus_in1 = 16'hffff;
      endcase
      unique case (c)
        2:       ebus = 16'h1234;
        3:       ebus = 16'h5678;
        default: ebus = 16'h0000;
      endcase
      checks++;
      if ({in_ready1, busy1, done1, lane_valid1} !==
          {(c == 1 || c == 2), (c >= 1 && c <= 4), (c == 4),
           (c == 2 || c == 3)}) begin
        errors++;
        $display("FAIL size1_ctl c=%0d got=%b", c,
                 {in_ready1, busy1, done1, lane_valid1});
      end
      checks++;
      if (bus_out1 !== ebus) begin
        errors++;
        $display("FAIL size1_bus c=%0d got=%h exp=%h", c, bus_out1, ebus);
      end
      @(negedge clk);
    end
    start1    = 1'b0;
    in_valid1 = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    bus_in    = '0;
    start1    = 1'b0;
    len1      = '0;
    in_valid1 = 1'b0;
    bus_in1   = '0;
    do_reset();
    test_reset();
    test_basic();
    @(negedge clk);
    test_bubbles();
    @(negedge clk);
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    @(negedge clk);
    test_size1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
